// File: rtl/regfile_param_clr_pkg.sv
// Shared definitions for the parametrised register file: default geometry
// and the clear-engine state encoding.
package regfile_param_clr_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_param_clr_clear_fsm.sv
// Sequential clear engine: walks the array one entry per cycle, owns the
// write-ready gate and the busy/done handshake toward the requester.
module regfile_param_clr_clear_fsm
  import regfile_param_clr_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              wr_ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset aborts any clear in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and Moore outputs; the pointer stops at the last entry.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    wr_ready_o = 1'b0;
    clr_we_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready_o = 1'b1;
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy_o = 1'b1;
        clr_we_o   = 1'b1;
        if (ptr_q == LastIdx) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        clr_done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign clr_idx_o = ptr_q;

endmodule

// File: rtl/regfile_param_clr.sv
// Parametrised 2-read/1-write register file with registered read ports,
// optional write-to-read bypass, optional hardwired-zero r0 and a
// sequential clear engine. Reads are plain muxes over the array.
module regfile_param_clr
  import regfile_param_clr_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_en1_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  output logic [WIDTH-1:0]  rd_data1_o,
  output logic              rd_valid1_o,
  input  logic              rd_en2_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [WIDTH-1:0]  rd_data2_o,
  output logic              rd_valid2_o,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
  logic [WIDTH-1:0]  rd_data2_q, rd_data2_d;
  logic              rd_valid1_q, rd_valid2_q;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_commit;

  regfile_param_clr_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_req_i  (clr_req_i),
    .clr_busy_o (clr_busy_o),
    .clr_done_o (clr_done_o),
    .wr_ready_o (wr_ready_o),
    .clr_we_o   (clr_we),
    .clr_idx_o  (clr_idx)
  );

  // A write lands only when accepted, in range and not aimed at a hardwired r0.
  always_comb begin
    wr_commit = wr_en_i && wr_ready_o && ({1'b0, wr_addr_i} < DepthW) &&
                !((ZERO_REG != 0) && (wr_addr_i == '0));
  end

  // Storage array: the clear engine and the write port never overlap because
  // wr_ready is low whenever the engine is writing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && (clr_idx == ADDR_W'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_commit && (wr_addr_i == ADDR_W'(i))) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Read muxes: out-of-range and hardwired-zero addresses fall through to 0;
  // the bypass forwards same-edge write data when enabled.
  always_comb begin
    rd_data1_d = '0;
    rd_data2_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr1_i == ADDR_W'(i)) rd_data1_d = mem_q[i];
      if (rd_addr2_i == ADDR_W'(i)) rd_data2_d = mem_q[i];
    end
    if ((ZERO_REG != 0) && (rd_addr1_i == '0)) rd_data1_d = '0;
    if ((ZERO_REG != 0) && (rd_addr2_i == '0)) rd_data2_d = '0;
    if ((BYPASS != 0) && wr_commit && (wr_addr_i == rd_addr1_i)) rd_data1_d = wr_data_i;
    if ((BYPASS != 0) && wr_commit && (wr_addr_i == rd_addr2_i)) rd_data2_d = wr_data_i;
  end

  // Registered read ports; data holds its last value when the port is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_valid1_q <= rd_en1_i;
      rd_valid2_q <= rd_en2_i;
      if (rd_en1_i) rd_data1_q <= rd_data1_d;
      if (rd_en2_i) rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_data1_o  = rd_data1_q;
  assign rd_data2_o  = rd_data2_q;
  assign rd_valid1_o = rd_valid1_q;
  assign rd_valid2_o = rd_valid2_q;

endmodule
